// File: rtl/uart_wb_bridge.sv
// UART debug-command responder: decodes host read/write frames and masters Wishbone cycles.
// Optional feature macro: WB_BRIDGE_TIMEOUT_EN abandons cycles the slave never acknowledges.
module uart_wb_bridge #(
    parameter int unsigned CLKS_PER_BIT   = 87,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        rx,
    output logic        tx,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {
        StIdle, StLen, StAddr, StWdata, StWbWr, StWbRd, StTxData
    } state_e;

    // ---------------------------------------------------------------- receiver
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    rx_state_e              rx_state_q, rx_state_d;
    logic [CntW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [2:0]             rx_bit_q, rx_bit_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic                   rx_valid, rx_ferr;
    logic [7:0]             rx_byte_q;
    logic                   rx_pend_q;
    logic                   rx_take;
    logic                   frame_err_q;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q[0] <= rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rx_prev_q <= rx_s;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_prev_q && !rx_s) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == HalfEnd) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_state_d = RxIdle;
                    // A low stop bit drops the byte outright.
                    if (rx_s) rx_valid = 1'b1;
                    else      rx_ferr  = 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_pend_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_pend_q   <= rx_valid | (rx_pend_q & ~rx_take);
            frame_err_q <= rx_ferr;
            if (rx_valid) rx_byte_q <= rx_shift_q;
        end
    end

    // ------------------------------------------------------------- transmitter
    logic            tx_q;
    logic            tx_active_q;
    logic [8:0]      tx_shift_q;
    logic [3:0]      tx_bit_q;
    logic [CntW-1:0] tx_cnt_q;
    logic            tx_load;
    logic [7:0]      tx_byte;
    logic            tx_ready;

    // Ready in the last stop-bit cycle so the next start bit follows with no gap.
    assign tx_ready = !tx_active_q || (tx_bit_q == 4'd9 && tx_cnt_q == BitEnd);

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_shift_q  <= '1;
            tx_bit_q    <= '0;
            tx_cnt_q    <= '0;
        end else if (tx_load) begin
            tx_q        <= 1'b0;
            tx_shift_q  <= {1'b1, tx_byte};
            tx_bit_q    <= '0;
            tx_cnt_q    <= '0;
            tx_active_q <= 1'b1;
        end else if (tx_active_q) begin
            if (tx_cnt_q == BitEnd) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_active_q <= 1'b0;
                    tx_q        <= 1'b1;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ command FSM
    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [8:0]  words_q, words_d;
    logic        wb_timeout;
    logic        wb_done;

    assign wb_done = cyc_q && (wbm_ack_i || wb_timeout);

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned    ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ToW-1:0] ToEnd = ToW'(TIMEOUT_CYCLES - 1);

    logic [ToW-1:0] to_cnt_q;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            to_cnt_q <= '0;
        end else if (!cyc_q || wb_done) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign wb_timeout = cyc_q && (to_cnt_q == ToEnd);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wb_timeout         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        rdat_d     = rdat_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        rx_take    = 1'b0;
        tx_load    = 1'b0;
        tx_byte    = rdat_q[31:24];
        unique case (state_q)
            StIdle: begin
                if (rx_pend_q) begin
                    rx_take = 1'b1;
                    if (rx_byte_q == 8'h01 || rx_byte_q == 8'h02) begin
                        we_d    = (rx_byte_q == 8'h01);
                        state_d = StLen;
                    end
                end
            end
            StLen: begin
                if (frame_err_q) begin
                    state_d = StIdle;
                end else if (rx_pend_q) begin
                    rx_take    = 1'b1;
                    words_d    = (rx_byte_q == 8'h00) ? 9'd256 : {1'b0, rx_byte_q};
                    byte_cnt_d = '0;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                if (frame_err_q) begin
                    state_d = StIdle;
                end else if (rx_pend_q) begin
                    rx_take    = 1'b1;
                    adr_d      = {adr_q[23:0], rx_byte_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = we_q ? StWdata : StWbRd;
                end
            end
            StWdata: begin
                if (frame_err_q) begin
                    state_d = StIdle;
                end else if (rx_pend_q) begin
                    rx_take    = 1'b1;
                    dat_d      = {dat_q[23:0], rx_byte_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = StWbWr;
                end
            end
            StWbWr, StWbRd: begin
                // Writes keep a byte that lands mid-cycle; reads discard host traffic.
                rx_take = !we_q && rx_pend_q;
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                end else if (wb_done) begin
                    cyc_d   = 1'b0;
                    adr_d   = adr_q + 32'd4;
                    words_d = words_q - 9'd1;
                    if (we_q) begin
                        state_d = (words_q == 9'd1) ? StIdle : StWdata;
                    end else begin
                        rdat_d     = wbm_ack_i ? wbm_dat_i : 32'hDEADBEEF;
                        byte_cnt_d = '0;
                        state_d    = StTxData;
                    end
                end
            end
            StTxData: begin
                rx_take = rx_pend_q;
                if (tx_ready) begin
                    tx_load    = 1'b1;
                    rdat_d     = {rdat_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = (words_q == 9'd0) ? StIdle : StWbRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdat_q     <= '0;
            byte_cnt_q <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdat_q     <= rdat_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
        end
    end

    assign tx        = tx_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q & we_q;
    assign wbm_sel_o = {4{cyc_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy      = (state_q != StIdle);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge at 8 clocks per bit, with a Wishbone slave and UART monitor.
// The timeout case runs only when WB_BRIDGE_TIMEOUT_EN is defined.
module tb_uart_wb_bridge;

    localparam int unsigned Cpb = 8;

    logic        clk, rst_n, rx, tx;
    logic        cyc, stb, we, ack, busy, frame_err;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cycle_n  = 0;
    int          fe_cnt   = 0;
    int          cyc_hi   = 0;

    uart_wb_bridge #(
        .CLKS_PER_BIT  (Cpb),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rstn_i(rst_n),
        .rx       (rx),
        .tx       (tx),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_we_o (we),
        .wbm_sel_o(sel),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i),
        .wbm_ack_i(ack),
        .busy     (busy),
        .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    always @(posedge clk) cycle_n <= cycle_n + 1;
    always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;
    always @(negedge clk) if (cyc === 1'b1) cyc_hi++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Wishbone slave: acks after ack_delay idle negedges, logs every acked cycle.
    logic          no_ack    = 1'b0;
    int            ack_delay = 0;
    int unsigned   ack_cycle = 0;
    logic [31:0]   rd_vals[$];
    logic [31:0]   log_adr[$];
    logic [31:0]   log_dat[$];
    logic          log_we[$];
    logic [3:0]    log_sel[$];

    initial begin
        int wait_n;
        wait_n = 0;
        ack    = 1'b0;
        dat_i  = '0;
        forever begin
            @(negedge clk);
            if (ack || cyc !== 1'b1) begin
                ack    = 1'b0;
                wait_n = 0;
            end else if (!no_ack) begin
                if (wait_n >= ack_delay) begin
                    ack       = 1'b1;
                    ack_cycle = cycle_n;
                    dat_i     = (rd_vals.size() > 0) ? rd_vals.pop_front() : 32'h0;
                    log_adr.push_back(adr);
                    log_dat.push_back(dat_o);
                    log_we.push_back(we);
                    log_sel.push_back(sel);
                end else begin
                    wait_n++;
                end
            end
        end
    end

    // UART monitor on tx: decodes bytes and records the cycle of each start bit.
    logic [7:0]  tx_bytes[$];
    int unsigned tx_start[$];
    int          tx_bad = 0;

    initial begin
        logic [7:0]  b;
        int unsigned t0;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t0 = cycle_n;
                repeat (Cpb / 2) @(negedge clk);
                if (tx !== 1'b0) tx_bad++;
                for (int i = 0; i < 8; i++) begin
                    repeat (Cpb) @(negedge clk);
                    b[i] = tx;
                end
                repeat (Cpb) @(negedge clk);
                if (tx !== 1'b1) tx_bad++;
                tx_bytes.push_back(b);
                tx_start.push_back(t0);
            end
        end
    end

    function automatic logic [31:0] tx_word(input int idx);
        return {tx_bytes[idx], tx_bytes[idx+1], tx_bytes[idx+2], tx_bytes[idx+3]};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Cpb) @(negedge clk);
        end
        rx = stop_bit;
        repeat (Cpb) @(negedge clk);
        rx = 1'b1;
    endtask

    // Sends the n low-order bytes of v, most significant first.
    task automatic send_bytes(input logic [127:0] v, input int n);
        for (int k = 0; k < n; k++) send_byte(v[8*(n-1-k) +: 8], 1'b1);
    endtask

    task automatic wait_log(input int n, input string tag);
        int budget;
        budget = 3000;
        while (log_adr.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq(tag, log_adr.size(), n);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int budget;
        budget = 4000;
        while (tx_bytes.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq(tag, tx_bytes.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 2000;
        while (busy !== 1'b0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    initial begin
        int lb;
        int tb;
        int fb;
        int ch;
        int bad_gaps;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_cyc", cyc, 1'b0);
        check_eq("rst_stb", stb, 1'b0);
        check_eq("rst_we", we, 1'b0);
        check_eq("rst_sel", sel, 4'h0);
        check_eq("rst_adr", adr, 32'h0);
        check_eq("rst_dat", dat_o, 32'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single-word write.
        lb = log_adr.size();
        send_bytes(80'h01_01_00000110_775555AB, 10);
        wait_log(lb + 1, "wr_count");
        check_eq("wr_adr", log_adr[lb], 32'h00000110);
        check_eq("wr_we", log_we[lb], 1'b1);
        check_eq("wr_dat", log_dat[lb], 32'h775555AB);
        check_eq("wr_sel", log_sel[lb], 4'hF);
        wait_idle("wr_idle");
        check_eq("wr_cyc_low", cyc, 1'b0);

        // Single-word read with a 3-cycle ack delay.
        ack_delay = 3;
        rd_vals.push_back(32'h775555AB);
        lb = log_adr.size();
        tb = tx_bytes.size();
        send_bytes(48'h02_01_00000110, 6);
        wait_tx(tb + 4, "rd1_count");
        check_eq("rd1_data", tx_word(tb), 32'h775555AB);
        for (int i = 1; i < 4; i++)
            check_eq($sformatf("rd1_gap%0d", i), tx_start[tb+i] - tx_start[tb+i-1], 80);
        check_eq("rd1_adr", log_adr[lb], 32'h00000110);
        check_eq("rd1_we", log_we[lb], 1'b0);
        check_eq("rd1_ack_to_tx", (tx_start[tb] - ack_cycle) <= 2, 1'b1);
        wait_idle("rd1_idle");

        // Two-word read across the address wrap.
        ack_delay = 0;
        rd_vals.push_back(32'h11223344);
        rd_vals.push_back(32'hA5A55A5A);
        lb = log_adr.size();
        tb = tx_bytes.size();
        send_bytes(48'h02_02_FFFFFFFC, 6);
        wait_tx(tb + 8, "rd2_count");
        check_eq("rd2_adr0", log_adr[lb], 32'hFFFFFFFC);
        check_eq("rd2_adr1", log_adr[lb+1], 32'h00000000);
        check_eq("rd2_data", {tx_word(tb), tx_word(tb + 4)}, 64'h11223344_A5A55A5A);
        bad_gaps = 0;
        for (int i = 1; i < 8; i++) if (tx_start[tb+i] - tx_start[tb+i-1] != 80) bad_gaps++;
        check_eq("rd2_gaps", bad_gaps, 0);
        wait_idle("rd2_idle");
        check_eq("tx_framing", tx_bad, 0);

        // Junk byte, then a command broken by a low stop bit, a glitch, then a good write.
        fb = fe_cnt;
        send_byte(8'h05, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("junk_busy", busy, 1'b0);
        send_byte(8'h01, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("cmd_busy", busy, 1'b1);
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("ferr_pulses", fe_cnt - fb, 1);
        check_eq("ferr_idle", busy, 1'b0);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        lb = log_adr.size();
        send_bytes(80'h01_01_00000200_CAFEF00D, 10);
        wait_log(lb + 1, "ferr_wr_count");
        check_eq("ferr_wr_adr", log_adr[lb], 32'h00000200);
        check_eq("ferr_wr_dat", log_dat[lb], 32'hCAFEF00D);
        wait_idle("ferr_wr_idle");

        // Reset during an unacknowledged read cycle.
        no_ack = 1'b1;
        send_bytes(48'h02_01_00000300, 6);
        begin
            int budget;
            budget = 500;
            while (cyc !== 1'b1 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
        end
        check_eq("mid_cyc_seen", cyc, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cyc", cyc, 1'b0);
        check_eq("mid_rst_stb", stb, 1'b0);
        check_eq("mid_rst_tx", tx, 1'b1);
        check_eq("mid_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        no_ack = 1'b0;
        repeat (4) @(negedge clk);
        lb = log_adr.size();
        send_bytes(80'h01_01_00000400_12345678, 10);
        wait_log(lb + 1, "post_rst_count");
        check_eq("post_rst_adr", log_adr[lb], 32'h00000400);
        check_eq("post_rst_dat", log_dat[lb], 32'h12345678);
        wait_idle("post_rst_idle");

`ifdef WB_BRIDGE_TIMEOUT_EN
        // Unacknowledged read gives up after 16 cycles and returns the filler word.
        no_ack = 1'b1;
        ch     = cyc_hi;
        tb     = tx_bytes.size();
        send_bytes(48'h02_01_00000040, 6);
        wait_tx(tb + 4, "to_count");
        check_eq("to_cyc_len", cyc_hi - ch, 16);
        check_eq("to_data", tx_word(tb), 32'hDEADBEEF);
        no_ack = 1'b0;
        wait_idle("to_idle");
`else
        ch = cyc_hi;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Device-side responder for the UART debug command protocol: deserialises host command frames, runs Wishbone master cycles, and serialises read data back to the host.
- Sits between the FPGA UART pins and the Caravel/NPU Wishbone bus.
- Host SRAM/register reads and writes go through this block during bring-up.

Parameters:
- CLKS_PER_BIT, 87, wb_clk_i cycles per UART bit. Legal range is 4 or greater.
- SYNC_STAGES, 2, number of flops in the rx synchroniser.
- TIMEOUT_CYCLES, 1024, Wishbone ack timeout. Used only with WB_BRIDGE_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  system clock
- wb_rstn_i  in  1  asynchronous active-low reset
- rx  in  1  UART line from host. Idle high.
- tx  out  1  UART line to host. Idle high.
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  1 = write
- wbm_sel_o  out  4  byte selects. Always 4'hF during a cycle.
- wbm_adr_o  out  32  byte address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  Wishbone acknowledge
- busy  out  1  high whenever the command FSM is not in IDLE
- frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset (asynchronous, wb_rstn_i low). All of the following take these values immediately:
  - tx=1
  - wbm_cyc_o, wbm_stb_o, wbm_we_o = 0
  - wbm_sel_o, wbm_adr_o, wbm_dat_o = 0
  - busy=0, frame_err=0
  - FSM in IDLE, all counters cleared
- Reset mid-frame or mid-cycle: the cycle is abandoned and no tx byte is completed.
- UART format: 8N1, LSB first.
- RX path:
  - rx passes through SYNC_STAGES flops.
  - A falling edge while the receiver is idle starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2. If rx is high there, the event is a glitch and is discarded.
  - Data bits are sampled at the centre of each bit, every CLKS_PER_BIT cycles.
  - Stop bit sampled low: the byte is dropped, frame_err pulses, and the command FSM returns to IDLE.
- TX path:
  - Start bit, 8 data bits, then 1 stop bit, each held exactly CLKS_PER_BIT cycles.
  - Read-data bytes are sent back-to-back with no extra idle time.
- Protocol, all multi-byte fields MSB first:
  - Write: 0x01, N, A3 A2 A1 A0, then N words of D3 D2 D1 D0.
  - Read: 0x02, N, A3 A2 A1 A0. Bridge replies with N words of D3 D2 D1 D0.
  - N=0 is treated as 256 words.
  - The address auto-increments by 4 after each word, wrapping modulo 2^32.
- Command FSM states: IDLE -> LEN -> ADDR(4 bytes) -> {WDATA(4 bytes) -> WB_WR} or {WB_RD -> TXDATA(4 bytes)} -> next word or IDLE.
  - IDLE: 0x01 or 0x02 advances to LEN. Any other byte is ignored and the FSM stays in IDLE.
  - WB_WR / WB_RD: cyc and stb rise together on the cycle after entry; adr and dat are stable.
  - The cycle ends on the first wbm_ack_i: cyc and stb drop on the next edge.
  - Read data is latched on the ack edge.
  - Only one cycle is outstanding at a time. A new cycle never starts in the same clock that ack is seen.
  - After the last word the FSM returns to IDLE.
- rx bytes that arrive while the FSM is in WB_RD or TXDATA are discarded. Host is half-duplex per command.
- Latency from the stop-bit sample of the last write byte to cyc rising: 2 cycles.
- Latency from ack to the tx start bit: 2 cycles or fewer.
- A receive counter reaching its bit/byte boundary in the same cycle as a framing error: the framing error wins.

Optional Feature:
- Macro: WB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs while cyc=1. If no ack arrives after TIMEOUT_CYCLES cycles, cyc and stb drop.
  - Reads return 32'hDEADBEEF for that word.
  - Writes are dropped.
  - The command then continues with the next word.
- Undefined: the bridge waits for ack indefinitely (it hangs if the slave never acks). No counter logic is synthesised.

Test Plan:
- CLKS_PER_BIT=8. Write 0x01,0x01,00 00 01 10,77 55 55 AB -> one Wishbone cycle with we=1, adr=0x00000110, dat_o=0x775555AB, sel=F. busy returns to 0 after ack.
- Read 0x02,0x01,00 00 01 10, slave returns 0x775555AB with 3-cycle ack delay -> tx bytes 77,55,55,AB, each frame exactly 10*8 cycles.
- Read N=2 at 0xFFFFFFFC -> adr sequence FFFFFFFC then 00000000. 8 tx bytes.
- Byte 0x05, then a stop bit forced low mid-command, then a valid write -> 0x05 ignored; the low stop bit pulses frame_err and returns the FSM to IDLE; the following valid write completes.
- Assert wb_rstn_i during an active Wishbone read cycle -> cyc, stb and tx go to idle values immediately; the next command works.
- With WB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> cyc drops after 16 cycles and tx returns DE AD BE EF.
